// File: rtl/bp_me_pkg.sv
// Shared layout, state encoding and packet type for the LCE command deserializer.
package bp_me_pkg;

    localparam int flit_width_p    = 64;
    localparam int cord_width_p    = 7;
    localparam int len_width_p     = 5;
    localparam int cid_width_p     = 2;
    localparam int msg_hdr_width_p = 96;
    localparam int data_width_p    = 512;

    localparam int pkt_width_lp  = cord_width_p + len_width_p + cid_width_p
                                 + msg_hdr_width_p + data_width_p;
    localparam int max_flits_lp  = (pkt_width_lp + flit_width_p - 1) / flit_width_p;
    localparam int addr_width_lp = $clog2(max_flits_lp);
    // one extra bit so the pointer can run past the buffer on an over-long packet
    localparam int ptr_width_lp  = len_width_p + 1;

    localparam int cord_offset_lp = 0;
    localparam int len_offset_lp  = cord_offset_lp + cord_width_p;
    localparam int cid_offset_lp  = len_offset_lp + len_width_p;
    localparam int hdr_offset_lp  = cid_offset_lp + cid_width_p;
    localparam int data_offset_lp = hdr_offset_lp + msg_hdr_width_p;

    typedef enum logic [1:0] {
        e_idle = 2'd0,
        e_body = 2'd1,
        e_full = 2'd2
    } state_e;

    // packed MSB-first, so the LSB-first wire order cord|len|cid|hdr|data reads bottom-up
    typedef struct packed {
        logic [data_width_p-1:0]    data;
        logic [msg_hdr_width_p-1:0] msg_hdr;
        logic [cid_width_p-1:0]     cid;
        logic [len_width_p-1:0]     len;
        logic [cord_width_p-1:0]    cord;
    } bp_lce_cmd_wormhole_packet_s;

endpackage

// File: rtl/bp_me_wormhole_lce_cmd_deserializer_if.sv
// Flit link plus valid/yumi consumer side of the LCE command deserializer.
interface bp_me_wormhole_lce_cmd_deserializer_if;
    import bp_me_pkg::*;

    logic [flit_width_p-1:0]    flit_i;
    logic                       flit_v_i;
    logic                       flit_ready_and_o;
    logic [msg_hdr_width_p-1:0] lce_cmd_header_o;
    logic [data_width_p-1:0]    lce_cmd_data_o;
    logic [cord_width_p-1:0]    cord_o;
    logic [cid_width_p-1:0]     cid_o;
    logic                       v_o;
    logic                       yumi_i;
    logic                       len_err_o;

    modport slave (
        input  flit_i, flit_v_i, yumi_i,
        output flit_ready_and_o, lce_cmd_header_o, lce_cmd_data_o,
               cord_o, cid_o, v_o, len_err_o
    );

    modport master (
        output flit_i, flit_v_i, yumi_i,
        input  flit_ready_and_o, lce_cmd_header_o, lce_cmd_data_o,
               cord_o, cid_o, v_o, len_err_o
    );

endinterface

// File: rtl/bsg_flit_sipo_buffer.sv
// Slot-addressed flit register array; the top slot is trimmed to the packet width.
module bsg_flit_sipo_buffer #(
    parameter int flit_width_p = 64,
    parameter int slots_p      = 10,
    parameter int out_width_p  = 622,
    parameter int addr_width_p = $clog2(slots_p)
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    input  logic                    i_clear,
    input  logic                    i_we,
    input  logic [addr_width_p-1:0] i_addr,
    input  logic [flit_width_p-1:0] i_flit,
    output logic [out_width_p-1:0]  o_data
);

    for (genvar gi = 0; gi < slots_p; gi++) begin : g_slot
        localparam int lo_lp = gi * flit_width_p;
        localparam int sw_lp = (out_width_p - lo_lp < flit_width_p) ? (out_width_p - lo_lp)
                                                                     : flit_width_p;
        logic [sw_lp-1:0] r_slot;

        // a write to this slot wins over the whole-buffer clear issued with the header flit
        always_ff @(posedge clk_i or negedge reset_n_i) begin
            if (!reset_n_i)
                r_slot <= '0;
            else if (i_we && (i_addr == addr_width_p'(gi)))
                r_slot <= i_flit[sw_lp-1:0];
            else if (i_clear)
                r_slot <= '0;
        end

        assign o_data[lo_lp +: sw_lp] = r_slot;
    end

endmodule

// File: rtl/bp_me_wormhole_lce_cmd_deserializer.sv
// Reassembles a wormhole packet into a bedrock LCE command for a valid/yumi consumer.
//
//   state  | meaning
//   e_idle | waiting for the header flit; clears buffer and latches len on accept
//   e_body | collecting the remaining len flits; flits past the buffer are dropped
//   e_full | packet held on the outputs until the consumer yumis
module bp_me_wormhole_lce_cmd_deserializer
    import bp_me_pkg::*;
(
    input  logic clk_i,
    input  logic reset_n_i,
    bp_me_wormhole_lce_cmd_deserializer_if.slave link
);

    state_e                      r_state, w_state_nxt;
    logic [len_width_p-1:0]      r_cnt, w_cnt_nxt;
    logic [ptr_width_lp-1:0]     r_ptr, w_ptr_nxt;
    logic                        r_len_err, w_len_err_nxt;
    logic                        w_ready, w_accept;
    logic                        w_clear, w_we;
    logic [addr_width_lp-1:0]    w_addr;
    logic [pkt_width_lp-1:0]     w_buf;
    bp_lce_cmd_wormhole_packet_s w_pkt;

    // ready drops while reset is held even though the state reads idle
    assign w_ready  = reset_n_i && (r_state != e_full);
    assign w_accept = link.flit_v_i && w_ready;

    // state, counters and sticky length error
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state   <= e_idle;
            r_cnt     <= '0;
            r_ptr     <= '0;
            r_len_err <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_ptr     <= w_ptr_nxt;
            r_len_err <= w_len_err_nxt;
        end
    end

    // next-state and buffer write control
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_ptr_nxt     = r_ptr;
        w_len_err_nxt = r_len_err;
        w_clear       = 1'b0;
        w_we          = 1'b0;
        w_addr        = '0;
        case (r_state)
            e_idle: begin
                if (w_accept) begin
                    w_clear   = 1'b1;
                    w_we      = 1'b1;
                    w_cnt_nxt = link.flit_i[len_offset_lp +: len_width_p];
                    w_ptr_nxt = ptr_width_lp'(1);
                    w_state_nxt = (w_cnt_nxt == '0) ? e_full : e_body;
                end
            end
            e_body: begin
                if (w_accept) begin
                    if (r_ptr < ptr_width_lp'(max_flits_lp)) begin
                        w_we   = 1'b1;
                        w_addr = r_ptr[addr_width_lp-1:0];
                    end else begin
                        w_len_err_nxt = 1'b1;
                    end
                    w_ptr_nxt = r_ptr + 1'b1;
                    w_cnt_nxt = r_cnt - 1'b1;
                    if (r_cnt == len_width_p'(1))
                        w_state_nxt = e_full;
                end
            end
            e_full: begin
                if (link.yumi_i)
                    w_state_nxt = e_idle;
            end
            default: w_state_nxt = e_idle;
        endcase
    end

    bsg_flit_sipo_buffer #(
        .flit_width_p (flit_width_p),
        .slots_p      (max_flits_lp),
        .out_width_p  (pkt_width_lp)
    ) u_buf (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .i_clear   (w_clear),
        .i_we      (w_we),
        .i_addr    (w_addr),
        .i_flit    (link.flit_i),
        .o_data    (w_buf)
    );

    assign w_pkt = bp_lce_cmd_wormhole_packet_s'(w_buf);

    assign link.flit_ready_and_o = w_ready;
    assign link.v_o              = (r_state == e_full);
    assign link.cord_o           = w_pkt.cord;
    assign link.cid_o            = w_pkt.cid;
    assign link.lce_cmd_header_o = w_pkt.msg_hdr;
    assign link.lce_cmd_data_o   = w_pkt.data;
    assign link.len_err_o        = r_len_err;

    // consumer may only take a packet that is actually presented
    a_yumi_needs_v: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        link.yumi_i |-> link.v_o)
        else $error("yumi_i asserted without v_o");

    // the pointer has advanced once per flit of the buffered packet
    a_ptr_matches_len: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        (r_state == e_full) |-> ({1'b0, w_pkt.len} == r_ptr - 1'b1))
        else $error("flit count disagrees with buffered len field");

endmodule

// File: doc/bp_me_wormhole_lce_cmd_deserializer.md
Name: bp_me_wormhole_lce_cmd_deserializer

Overview:
Receive-side endpoint for the coherence command network. It accepts wormhole flits from a ready-and link and reassembles one packet laid out as cord|len|cid|msg_hdr|data, LSB first. It then presents a bedrock LCE command (header plus data) to a valid/yumi consumer, such as an accelerator LCE or the CCE command sink. It is the inverse of the encode-plus-adapter-in path used on transmit.

Parameters:
flit_width_p, 64, width of one network flit
cord_width_p, 7, destination coordinate field width
len_width_p, 5, length field width; value = number of flits after the header flit
cid_width_p, 2, concentrator id field width
msg_hdr_width_p, 96, bedrock LCE cmd header width
data_width_p, 512, maximum payload width (cce_block_width_p)
(derived) pkt_width_lp = cord+len+cid+msg_hdr+data widths; max_flits_lp = ceil(pkt_width_lp/flit_width_p)

Ports:
clk_i  in  1  clock
reset_n_i  in  1  asynchronous, active-low reset
flit_i  in  flit_width_p  incoming flit
flit_v_i  in  1  flit valid
flit_ready_and_o  out  1  flit accepted when flit_v_i & flit_ready_and_o
lce_cmd_header_o  out  msg_hdr_width_p  decoded bedrock header
lce_cmd_data_o  out  data_width_p  payload; bits not covered by received flits are zero
cord_o  out  cord_width_p  received destination cord
cid_o  out  cid_width_p  received cid
v_o  out  1  complete packet held
yumi_i  in  1  consumer takes packet; legal only when v_o
len_err_o  out  1  sticky: a packet arrived with len > max_flits_lp-1

Behaviour:
- Reset (async assert, sync release): state=e_idle, buffer=0, counter=0, v_o=0, flit_ready_and_o=0 while reset is held, len_err_o=0. All data outputs are 0.
- e_idle: flit_ready_and_o=1. On an accepted flit:
  - Clear the whole buffer, then write the flit into slot 0.
  - Latch len = flit_i[cord_width_p +: len_width_p] into the remaining-flit counter.
  - Write pointer = 1.
  - If len==0, go to e_full. Otherwise go to e_body.
- e_body: flit_ready_and_o=1. On each accepted flit:
  - If pointer < max_flits_lp, write the flit into slot[pointer]. Otherwise drop the flit and set len_err_o.
  - Increment the pointer and decrement the counter.
  - When an accepted flit arrives with counter==1, go to e_full.
- e_full: v_o=1 and flit_ready_and_o=0. No bypass: a packet takes len+1 accept cycles plus at least one output cycle. On yumi_i, go to e_idle. The next flit can be accepted in the following cycle.
- Throughput is 1 flit/cycle within a packet. Latency is 1 cycle from the last flit accepted to v_o.
- Slicing is registered from the buffer. The top slot is truncated to pkt_width_lp.
  - cord_o = buf[0 +: cord]
  - cid_o = buf[cord+len +: cid]
  - header = next msg_hdr bits
  - data = remaining bits
- yumi_i without v_o is illegal; an assertion flags it. flit_v_i low in mid-packet stalls the block with no timeout.
- Reset asserted mid-packet discards the partial packet immediately. len_err_o clears only on reset.
- Outputs stay stable while v_o=1 and yumi_i=0.

Decomposition:
- A shared package (bp_me_pkg) holds:
  - the packet-layout offset localparams
  - a state enum e_idle/e_body/e_full
  - the `declare_bp_lce_cmd_wormhole_packet_s usage for typed slicing
- One sub-module, bsg_flit_sipo_buffer, is the natural split: a slot-addressed flit register array with clear-on-first and write-enable. The FSM and counter stay in the top module.

Test Plan:
- Single-flit packet, len=0, cord=5, cid=1 → v_o on the cycle after accept; cord_o=5, cid_o=1, data=0; after yumi, flit_ready_and_o=1 on the next cycle.
- Full 512-bit block, len=max_flits_lp-1, flits sent back-to-back → every flit accepted on consecutive cycles; lce_cmd_data_o equals the sent block bit-exact.
- Same packet with flit_v_i deasserted for 3 cycles mid-body → no flit lost; identical output; v_o only after the final flit.
- Packet held with yumi_i=0 for 10 cycles while flit_v_i=1 → flit_ready_and_o=0 and outputs stable throughout; a new packet starts only after yumi.
- Short packet (len=1) following a full packet → upper data bits read 0, with no residue from the previous packet.
- reset_n_i pulsed low after 2 of 9 flits → v_o=0 immediately; a fresh packet then decodes correctly. Sending len=31 afterwards → len_err_o=1, excess flits consumed, and v_o still asserts after 32 flits.
